// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage: one-cycle ops, bit-serial shifts, registered result with valid/ready on both sides.
// Latency: 1 cycle for non-shift ops, 1+b[4:0] cycles for shifts; back-to-back issue when downstream is ready.
module alu_exec_stage #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              illegal
);

    localparam int SHW = $clog2(DWIDTH);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SLL    = 4'd1;
    localparam logic [3:0] OP_SLT    = 4'd2;
    localparam logic [3:0] OP_SLTU   = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SRL    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_AND    = 4'd7;
    localparam logic [3:0] OP_COPY_A = 4'd10;
    localparam logic [3:0] OP_COPY_B = 4'd11;
    localparam logic [3:0] OP_SUB    = 4'd12;
    localparam logic [3:0] OP_SRA    = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shdir_e;

    state_e            state_q;
    shdir_e            dir_q;
    logic [SHW-1:0]    cnt_q;
    logic [DWIDTH-1:0] shreg_q;
    logic [DWIDTH-1:0] result_q;
    logic              illegal_q;
    logic              out_valid_q;

    logic              accept;
    logic              retire;
    logic [SHW-1:0]    shamt;
    logic [SHW-1:0]    cnt_d;
    logic [DWIDTH-1:0] shreg_d;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_ill;
    logic              is_shift;
    shdir_e            op_dir;

    // in_ready is the only output with a combinational input (out_ready).
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign shamt     = b[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        op_dir   = SH_LL;
        case (alu_op)
            OP_ADD:    alu_res = a + b;
            OP_SUB:    alu_res = a - b;
            OP_SLT:    alu_res = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:   alu_res = {{(DWIDTH-1){1'b0}}, (a < b)};
            OP_XOR:    alu_res = a ^ b;
            OP_OR:     alu_res = a | b;
            OP_AND:    alu_res = a & b;
            OP_COPY_A: alu_res = a;
            OP_COPY_B: alu_res = b;
            // A zero shift amount completes immediately with a unchanged.
            OP_SLL: begin
                is_shift = 1'b1;
                op_dir   = SH_LL;
                alu_res  = a;
            end
            OP_SRL: begin
                is_shift = 1'b1;
                op_dir   = SH_RL;
                alu_res  = a;
            end
            OP_SRA: begin
                is_shift = 1'b1;
                op_dir   = SH_RA;
                alu_res  = a;
            end
            default:   alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        case (dir_q)
            SH_LL:   shreg_d = {shreg_q[DWIDTH-2:0], 1'b0};
            SH_RL:   shreg_d = {1'b0, shreg_q[DWIDTH-1:1]};
            default: shreg_d = {shreg_q[DWIDTH-1], shreg_q[DWIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= SH_LL;
            cnt_q       <= '0;
            shreg_q     <= '0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            if (cnt_d == '0) begin
                result_q    <= shreg_d;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
            end
        end else if (accept) begin
            // Covers both a fresh issue from IDLE and retire-plus-issue from DONE.
            illegal_q <= alu_ill;
            dir_q     <= op_dir;
            if (is_shift && (shamt != '0)) begin
                shreg_q     <= a;
                cnt_q       <= shamt;
                out_valid_q <= 1'b0;
                state_q     <= ST_SHIFT;
            end else begin
                result_q    <= alu_res;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
            end
        end else if (retire) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
        end
    end

endmodule
